dense_layer_engine: RTL
=======================

Name: dense_layer_engine

Overview:
Sequential fully-connected layer engine and the successor to the single-neuron hidden node. It computes OUT_DIM neurons over one IN_DIM input vector using LANES parallel signed MAC lanes and fetches weights from an external synchronous memory. Each neuron result is requantised with a round-and-shift stage, passed through an optional ReLU and saturated to DATA_W. It sits between the input-vector source and the next layer, and uses valid/ready handshakes on both sides.

Parameters:
IN_DIM, 64, inputs per neuron (≥2)
OUT_DIM, 16, neurons in the layer
LANES, 4, parallel MAC lanes; OUT_DIM % LANES == 0; G = OUT_DIM/LANES groups
DATA_W, 8, signed two's-complement width of inputs, weights and outputs
ACC_W, 32, signed accumulator width; must be ≥ 2*DATA_W + clog2(IN_DIM) + 1
SHIFT_W, 5, width of the requant shift field

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input vector and configuration valid
in_ready  out  1  engine idle and able to accept
in_vec  in  DATA_W*IN_DIM  input x[i] at [i*DATA_W +: DATA_W], signed
bias_vec  in  ACC_W*OUT_DIM  bias for neuron n at [n*ACC_W +: ACC_W], signed
relu_en  in  1  1 = apply ReLU before saturation
shift  in  SHIFT_W  arithmetic right shift applied to the accumulator
w_rd_en  out  1  weight memory read strobe
w_addr  out  clog2(G*IN_DIM)  weight address = g*IN_DIM + i
w_data  in  LANES*DATA_W  read data, valid exactly 1 cycle after w_rd_en; lane l = W[g*LANES+l][i]
out_valid  out  1  result vector valid
out_ready  in  1  downstream accepts
out_vec  out  DATA_W*OUT_DIM  neuron n at [n*DATA_W +: DATA_W], signed
busy  out  1  high in every state except IDLE

Behaviour:
- Reset is asynchronous, active-low, clock clk. Reset values: state IDLE, in_ready=1, out_valid=0, out_vec=0, w_rd_en=0, w_addr=0, busy=0, accumulators=0.
- in_ready = (state==IDLE). A transfer occurs when in_valid&in_ready is high at a rising edge.
- On transfer, latch in_vec, bias_vec, relu_en and shift. Later changes to these inputs are ignored until the next transfer.
- States: IDLE -> ISSUE -> DRAIN -> STORE -> (ISSUE for the next group | OUT) -> IDLE.
- IDLE: on transfer, set g=0 and i=0, load lane accumulators with bias[g*LANES+l], then go to ISSUE.
- ISSUE: lasts IN_DIM cycles. w_rd_en=1 and w_addr=g*IN_DIM+i, with i incrementing every cycle. After i==IN_DIM-1, go to DRAIN.
- Accumulation: in the cycle after each read, each lane does acc += sext(x[i_prev]) * sext(w_data lane). The product is a full 2*DATA_W signed value, and the accumulator wraps modulo 2^ACC_W. The final MAC of a group occurs in DRAIN. w_rd_en=0 in DRAIN.
- STORE (1 cycle): requantise each lane into out_vec[g*LANES+l]. If g<G-1, set g++, i=0, reload accumulators with the next group's biases, and go to ISSUE. Otherwise go to OUT.
- Requant pipeline, in this order:
  - If shift>0, add 2^(shift-1) (round half up), then arithmetic shift right by shift.
  - If relu_en and the value is negative, replace it with 0.
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Latency: out_valid rises exactly G*(IN_DIM+2) cycles after the accepting edge. There is a 2-cycle w_rd_en gap between groups.
- OUT: out_valid=1. out_vec is stable and w_rd_en=0 while out_ready=0 (backpressure of any length). Handshake at an edge -> IDLE, out_valid=0. in_ready rises in the following cycle; there is no same-cycle re-accept.
- in_valid while busy is ignored and not queued.
- Reset in any state: abort immediately to the reset values. No partial out_valid is produced afterwards.
- shift ≥ ACC_W gives 0 for non-negative accumulators and -1 for negative ones before ReLU/saturation.

Test Plan:
Every scenario uses IN_DIM=4, OUT_DIM=8, LANES=4, DATA_W=8, ACC_W=24, and a bench weight memory with 1-cycle read latency.
1. All x=1, all W=1, bias=0, shift=0, relu_en=0 -> all 8 outputs = 4. out_valid rises 12 cycles after accept. w_addr sequence is 0,1,2,3, then a 2-cycle gap, then 4,5,6,7.
2. x=127, W=127, bias=0 -> acc=64516 -> output 127. x=127, W=-128 -> acc=-65024 -> output -128. Same with relu_en=1 -> output 0.
3. x=0, bias=6, shift=2 -> 2. x=0, bias=-6, shift=2 -> -1. x=0, bias=5, shift=0 -> 5.
4. Per-lane distinct weights, e.g. lane l weight = l-2, with x=(1,2,3,4) and bias=n -> out[n] = 10*((n%4)-2) + n, before saturation.
5. Hold out_ready=0 for 10 cycles after out_valid -> out_vec and out_valid stay stable, in_ready=0, w_rd_en=0. in_valid pulses during busy produce no extra result.
6. Assert rst_n low during ISSUE of group 1 -> all outputs at their reset values. The next transaction (scenario 1 stimulus) completes correctly with latency 12.

Source files
------------

// File: rtl/dense_layer_engine.sv
// Sequential fully-connected layer: LANES signed MAC lanes sweep OUT_DIM neurons in groups,
// streaming weights from a 1-cycle-latency memory, then round/shift, optional ReLU, saturate.
module dense_lane #(
   parameter int DATA_W  = 8,
   parameter int ACC_W   = 32,
   parameter int SHIFT_W = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               mac_en,
   input  logic [ACC_W-1:0]   bias,
   input  logic [DATA_W-1:0]  x,
   input  logic [DATA_W-1:0]  w,
   input  logic [SHIFT_W-1:0] shift,
   input  logic               relu_en,
   output logic [DATA_W-1:0]  res
);
   localparam logic signed [ACC_W:0] SMAX = (ACC_W+1)'((1 << (DATA_W-1)) - 1);
   localparam logic signed [ACC_W:0] SMIN = -SMAX - 1;

   logic signed [ACC_W-1:0]    acc_q, acc_d;
   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W:0]      ext, rnd, sh;

   assign prod = $signed(x) * $signed(w);

   always_comb begin
      acc_d = acc_q;
      if (load)
         acc_d = bias;
      else if (mac_en)
         acc_d = acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) acc_q <= '0;
      else        acc_q <= acc_d;

   // One extra bit of headroom so the rounding add cannot wrap.
   always_comb begin
      ext = {acc_q[ACC_W-1], acc_q};
      rnd = '0;
      sh  = '0;
      if (32'(shift) >= ACC_W) begin
         sh = acc_q[ACC_W-1] ? '1 : '0;
      end else begin
         if (shift != '0) rnd = (ACC_W+1)'(1) << (shift - SHIFT_W'(1));
         sh = (ext + rnd) >>> shift;
      end
      if (relu_en && sh[ACC_W]) sh = '0;
      if (sh > SMAX)      res = SMAX[DATA_W-1:0];
      else if (sh < SMIN) res = SMIN[DATA_W-1:0];
      else                res = sh[DATA_W-1:0];
   end
endmodule

module dense_layer_engine #(
   parameter int IN_DIM  = 64,
   parameter int OUT_DIM = 16,
   parameter int LANES   = 4,
   parameter int DATA_W  = 8,
   parameter int ACC_W   = 32,
   parameter int SHIFT_W = 5,
   localparam int G      = OUT_DIM / LANES,
   localparam int AW     = $clog2(G*IN_DIM)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_W*IN_DIM-1:0]  in_vec,
   input  logic [ACC_W*OUT_DIM-1:0]  bias_vec,
   input  logic                      relu_en,
   input  logic [SHIFT_W-1:0]        shift,
   output logic                      w_rd_en,
   output logic [AW-1:0]             w_addr,
   input  logic [LANES*DATA_W-1:0]   w_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_W*OUT_DIM-1:0] out_vec,
   output logic                      busy
);
   localparam int IW = $clog2(IN_DIM);
   localparam int GW = (G > 1) ? $clog2(G) : 1;

   typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, STORE, OUT} state_t;

   state_t                     state_q, state_d;
   logic [GW-1:0]              g_q, g_d, load_g;
   logic [IW-1:0]              i_q, i_d, i_prev_q;
   logic                       rd_vld_q;
   logic [DATA_W*IN_DIM-1:0]   x_q, x_d;
   logic [ACC_W*OUT_DIM-1:0]   bias_q, bias_d, bias_src;
   logic                       relu_q, relu_d;
   logic [SHIFT_W-1:0]         shift_q, shift_d;
   logic [DATA_W*OUT_DIM-1:0]  out_vec_q, out_vec_d;
   logic                       load;
   logic [DATA_W-1:0]          x_cur;
   logic [LANES-1:0][ACC_W-1:0]  lane_bias;
   logic [LANES-1:0][DATA_W-1:0] lane_res;

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = (state_q == OUT);
   assign out_vec   = out_vec_q;
   assign w_rd_en   = (state_q == ISSUE);
   assign w_addr    = w_rd_en ? AW'(int'(g_q)*IN_DIM + int'(i_q)) : '0;
   assign x_cur     = x_q[int'(i_prev_q)*DATA_W +: DATA_W];

   always_comb begin
      state_d   = state_q;
      g_d       = g_q;
      i_d       = i_q;
      x_d       = x_q;
      bias_d    = bias_q;
      relu_d    = relu_q;
      shift_d   = shift_q;
      out_vec_d = out_vec_q;
      load      = 1'b0;
      load_g    = g_q;
      case (state_q)
         IDLE: if (in_valid) begin
            state_d = ISSUE;
            x_d     = in_vec;
            bias_d  = bias_vec;
            relu_d  = relu_en;
            shift_d = shift;
            g_d     = '0;
            i_d     = '0;
            load    = 1'b1;
            load_g  = '0;
         end
         ISSUE: begin
            i_d = i_q + 1'b1;
            if (i_q == IW'(IN_DIM-1)) begin
               i_d     = '0;
               state_d = DRAIN;
            end
         end
         DRAIN: state_d = STORE;
         STORE: begin
            for (int l = 0; l < LANES; l++)
               out_vec_d[(int'(g_q)*LANES + l)*DATA_W +: DATA_W] = lane_res[l];
            if (g_q == GW'(G-1)) begin
               state_d = OUT;
            end else begin
               g_d     = g_q + 1'b1;
               load    = 1'b1;
               load_g  = g_q + 1'b1;
               state_d = ISSUE;
            end
         end
         OUT: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The first group's biases come straight off the port on the accepting edge.
   always_comb begin
      bias_src = (state_q == IDLE) ? bias_vec : bias_q;
      for (int l = 0; l < LANES; l++)
         lane_bias[l] = bias_src[(int'(load_g)*LANES + l)*ACC_W +: ACC_W];
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q   <= IDLE;
         g_q       <= '0;
         i_q       <= '0;
         i_prev_q  <= '0;
         rd_vld_q  <= 1'b0;
         x_q       <= '0;
         bias_q    <= '0;
         relu_q    <= 1'b0;
         shift_q   <= '0;
         out_vec_q <= '0;
      end else begin
         state_q   <= state_d;
         g_q       <= g_d;
         i_q       <= i_d;
         i_prev_q  <= i_q;
         rd_vld_q  <= w_rd_en;
         x_q       <= x_d;
         bias_q    <= bias_d;
         relu_q    <= relu_d;
         shift_q   <= shift_d;
         out_vec_q <= out_vec_d;
      end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      dense_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SHIFT_W(SHIFT_W)) u_lane (
         .clk     (clk),
         .rst_n   (rst_n),
         .load    (load),
         .mac_en  (rd_vld_q),
         .bias    (lane_bias[l]),
         .x       (x_cur),
         .w       (w_data[l*DATA_W +: DATA_W]),
         .shift   (shift_q),
         .relu_en (relu_q),
         .res     (lane_res[l])
      );
   end
endmodule
